// File: rtl/lparray_down_collector.sv
// lparray_down_collector
//
// Serializes the per-column down streams leaving the bottom row of the
// linear-processing systolic array into a single AXI-Stream. Beats leave in
// column order 0..PE_NUMBER_I-1, one row at a time. The block also checks that
// every column of a row agrees on tlast and on the enabled sideband fields.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   s_axis_down_tdata        PE_NUMBER_I lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_down_tvalid/ready per-lane handshake
//   s_axis_down_tlast        per-lane last
//   s_axis_down_tid/tdest/tuser  per-lane sideband, packed like tdata
//   m_axis_*                 serialized output stream; tid/tdest/tuser read 0 when disabled
//   m_axis_tlast             high only on the final beat of a row
//   err_unalligned_data      one-cycle pulse: lanes of a row disagreed on tlast
//   err_user_flag            one-cycle pulse: a row's tdest/tuser differed from lane 0

module lparray_down_collector #(
    parameter int PE_NUMBER_I = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 1,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PE_NUMBER_I*DATA_WIDTH-1:0] s_axis_down_tdata,
    input  logic [PE_NUMBER_I-1:0]            s_axis_down_tvalid,
    output logic [PE_NUMBER_I-1:0]            s_axis_down_tready,
    input  logic [PE_NUMBER_I-1:0]            s_axis_down_tlast,
    input  logic [PE_NUMBER_I*ID_WIDTH-1:0]   s_axis_down_tid,
    input  logic [PE_NUMBER_I*DEST_WIDTH-1:0] s_axis_down_tdest,
    input  logic [PE_NUMBER_I*USER_WIDTH-1:0] s_axis_down_tuser,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [ID_WIDTH-1:0]               m_axis_tid,
    output logic [DEST_WIDTH-1:0]             m_axis_tdest,
    output logic [USER_WIDTH-1:0]             m_axis_tuser,
    output logic                              err_unalligned_data,
    output logic                              err_user_flag
);

    localparam int SEL_W = (PE_NUMBER_I > 1) ? $clog2(PE_NUMBER_I) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(PE_NUMBER_I - 1);

    // Per-lane one-entry holding registers
    logic [PE_NUMBER_I-1:0] hold_valid_r;
    logic [PE_NUMBER_I-1:0] hold_last_r;
    logic [DATA_WIDTH-1:0]  hold_data_r [PE_NUMBER_I];
    logic [ID_WIDTH-1:0]    hold_id_r   [PE_NUMBER_I];
    logic [DEST_WIDTH-1:0]  hold_dest_r [PE_NUMBER_I];
    logic [USER_WIDTH-1:0]  hold_user_r [PE_NUMBER_I];

    // Row sequencing and consistency state
    logic [SEL_W-1:0]       sel_r;
    logic                   last_or_r;
    logic                   last_and_r;
    logic                   user_mis_r;
    logic [DEST_WIDTH-1:0]  ref_dest_r;
    logic [USER_WIDTH-1:0]  ref_user_r;
    logic                   err_unaligned_r;
    logic                   err_user_r;

    logic                   out_hs_s;
    logic                   row_end_s;
    logic                   beat_last_s;
    logic                   beat_mis_s;
    logic                   last_or_next_s;
    logic                   last_and_next_s;
    logic [DEST_WIDTH-1:0]  beat_dest_s;
    logic [USER_WIDTH-1:0]  beat_user_s;

    // Current beat decode and row-consistency terms for the selected lane
    always_comb begin
        out_hs_s        = hold_valid_r[sel_r] & m_axis_tready;
        row_end_s       = out_hs_s & (sel_r == LAST_SEL);
        beat_last_s     = hold_last_r[sel_r];
        beat_dest_s     = hold_dest_r[sel_r];
        beat_user_s     = hold_user_r[sel_r];
        last_or_next_s  = last_or_r | beat_last_s;
        last_and_next_s = last_and_r & beat_last_s;
        // Lane 0 defines the reference, so it can never mismatch itself.
        if (sel_r != {SEL_W{1'b0}}) begin
            beat_mis_s = ((DEST_ENABLE != 0) && (beat_dest_s != ref_dest_r)) ||
                         ((USER_ENABLE != 0) && (beat_user_s != ref_user_r));
        end else begin
            beat_mis_s = 1'b0;
        end
    end

    // Lane ready: empty slot, or the selected slot draining this cycle (refill)
    always_comb begin
        s_axis_down_tready = {PE_NUMBER_I{1'b0}};
        for (int i = 0; i < PE_NUMBER_I; i++) begin
            s_axis_down_tready[i] = ~hold_valid_r[i] | (out_hs_s & (sel_r == SEL_W'(i)));
        end
    end

    // Holding registers: load on input handshake, clear when emitted without refill
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_r <= {PE_NUMBER_I{1'b0}};
            hold_last_r  <= {PE_NUMBER_I{1'b0}};
            for (int i = 0; i < PE_NUMBER_I; i++) begin
                hold_data_r[i] <= {DATA_WIDTH{1'b0}};
                hold_id_r[i]   <= {ID_WIDTH{1'b0}};
                hold_dest_r[i] <= {DEST_WIDTH{1'b0}};
                hold_user_r[i] <= {USER_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < PE_NUMBER_I; i++) begin
                if (s_axis_down_tvalid[i] & s_axis_down_tready[i]) begin
                    hold_valid_r[i] <= 1'b1;
                    hold_last_r[i]  <= s_axis_down_tlast[i];
                    hold_data_r[i]  <= s_axis_down_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    hold_id_r[i]    <= s_axis_down_tid[i*ID_WIDTH +: ID_WIDTH];
                    hold_dest_r[i]  <= s_axis_down_tdest[i*DEST_WIDTH +: DEST_WIDTH];
                    hold_user_r[i]  <= s_axis_down_tuser[i*USER_WIDTH +: USER_WIDTH];
                end else if (out_hs_s & (sel_r == SEL_W'(i))) begin
                    hold_valid_r[i] <= 1'b0;
                end else begin
                    hold_valid_r[i] <= hold_valid_r[i];
                end
            end
        end
    end

    // Column pointer, row accumulators and registered error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r           <= {SEL_W{1'b0}};
            last_or_r       <= 1'b0;
            last_and_r      <= 1'b1;
            user_mis_r      <= 1'b0;
            ref_dest_r      <= {DEST_WIDTH{1'b0}};
            ref_user_r      <= {USER_WIDTH{1'b0}};
            err_unaligned_r <= 1'b0;
            err_user_r      <= 1'b0;
        end else if (row_end_s) begin
            // Final column: report the row and return accumulators to identity.
            sel_r           <= {SEL_W{1'b0}};
            last_or_r       <= 1'b0;
            last_and_r      <= 1'b1;
            user_mis_r      <= 1'b0;
            err_unaligned_r <= last_or_next_s ^ last_and_next_s;
            err_user_r      <= user_mis_r | beat_mis_s;
        end else if (out_hs_s) begin
            sel_r           <= sel_r + SEL_W'(1);
            last_or_r       <= last_or_next_s;
            last_and_r      <= last_and_next_s;
            user_mis_r      <= user_mis_r | beat_mis_s;
            err_unaligned_r <= 1'b0;
            err_user_r      <= 1'b0;
            if (sel_r == {SEL_W{1'b0}}) begin
                ref_dest_r <= beat_dest_s;
                ref_user_r <= beat_user_s;
            end else begin
                ref_dest_r <= ref_dest_r;
                ref_user_r <= ref_user_r;
            end
        end else begin
            err_unaligned_r <= 1'b0;
            err_user_r      <= 1'b0;
        end
    end

    // Output stream is a mux of the selected lane's holding register
    always_comb begin
        m_axis_tvalid = hold_valid_r[sel_r];
        m_axis_tdata  = hold_data_r[sel_r];
        // Only the final column may signal end of row-block.
        m_axis_tlast  = (sel_r == LAST_SEL) & (last_or_r | beat_last_s);
        if (ID_ENABLE != 0) begin
            m_axis_tid = hold_id_r[sel_r];
        end else begin
            m_axis_tid = {ID_WIDTH{1'b0}};
        end
        if (DEST_ENABLE != 0) begin
            m_axis_tdest = beat_dest_s;
        end else begin
            m_axis_tdest = {DEST_WIDTH{1'b0}};
        end
        if (USER_ENABLE != 0) begin
            m_axis_tuser = beat_user_s;
        end else begin
            m_axis_tuser = {USER_WIDTH{1'b0}};
        end
    end

    assign err_unalligned_data = err_unaligned_r;
    assign err_user_flag       = err_user_r;

endmodule

// File: tb/tb_lparray_down_collector.sv
// Directed testbench for lparray_down_collector: a 4-lane instance exercises
// ordering, latency, stalls, tlast/sideband checks and mid-row reset; a
// 1-lane instance checks pass-through at one beat per cycle.

module tb_lparray_down_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // 4-lane instance
    logic [63:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tready;
    logic [3:0]  s_tlast;
    logic [31:0] s_tid;
    logic [31:0] s_tdest;
    logic [31:0] s_tuser;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [7:0]  m_tid;
    logic [7:0]  m_tdest;
    logic [7:0]  m_tuser;
    logic        err_al;
    logic        err_us;
    // 1-lane instance
    logic [15:0] s1_tdata;
    logic        s1_tvalid;
    logic        s1_tready;
    logic        s1_tlast;
    logic [15:0] m1_tdata;
    logic        m1_tvalid;
    logic        m1_tready;
    logic        m1_tlast;
    logic [7:0]  m1_tid;
    logic [7:0]  m1_tdest;
    logic [7:0]  m1_tuser;
    logic        err1_al;
    logic        err1_us;

    lparray_down_collector #(.PE_NUMBER_I(4)) dut (
        .clk(clk), .rst(rst),
        .s_axis_down_tdata(s_tdata), .s_axis_down_tvalid(s_tvalid),
        .s_axis_down_tready(s_tready), .s_axis_down_tlast(s_tlast),
        .s_axis_down_tid(s_tid), .s_axis_down_tdest(s_tdest), .s_axis_down_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
        .m_axis_tuser(m_tuser), .err_unalligned_data(err_al), .err_user_flag(err_us)
    );

    lparray_down_collector #(.PE_NUMBER_I(1)) dut1 (
        .clk(clk), .rst(rst),
        .s_axis_down_tdata(s1_tdata), .s_axis_down_tvalid(s1_tvalid),
        .s_axis_down_tready(s1_tready), .s_axis_down_tlast(s1_tlast),
        .s_axis_down_tid(8'h00), .s_axis_down_tdest(8'h00), .s_axis_down_tuser(8'h00),
        .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
        .m_axis_tlast(m1_tlast), .m_axis_tid(m1_tid), .m_axis_tdest(m1_tdest),
        .m_axis_tuser(m1_tuser), .err_unalligned_data(err1_al), .err_user_flag(err1_us)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lane0_acc = 0;
    logic rand_mode = 1'b0;
    logic hold_rdy  = 1'b0;

    // Monitor state (written only by the monitor)
    logic [15:0] q_data [$];
    logic        q_last [$];
    logic [7:0]  q_dest [$];
    int          q_stamp[$];
    logic [15:0] q1_data [$];
    logic        q1_last [$];
    int          q1_stamp[$];
    int          n_err_al = 0;
    int          n_err_us = 0;
    int          n_err1   = 0;
    int          n_unstable = 0;
    logic        stall_r = 1'b0;
    logic [33:0] held_r = 34'd0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle counter: number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // Output ready generator; applied just after each rising edge
    always @(posedge clk) begin
        #2;
        m_tready = hold_rdy ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Output monitor sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_r && ({m_tvalid, m_tlast, m_tdata, m_tdest, m_tuser} != held_r))
                n_unstable <= n_unstable + 1;
            if (m_tvalid && m_tready) begin
                q_data.push_back(m_tdata);
                q_last.push_back(m_tlast);
                q_dest.push_back(m_tdest);
                q_stamp.push_back(cyc);
            end
            if (m1_tvalid && m1_tready) begin
                q1_data.push_back(m1_tdata);
                q1_last.push_back(m1_tlast);
                q1_stamp.push_back(cyc);
            end
            stall_r <= m_tvalid & ~m_tready;
            held_r  <= {m_tvalid, m_tlast, m_tdata, m_tdest, m_tuser};
            if (err_al) n_err_al <= n_err_al + 1;
            if (err_us) n_err_us <= n_err_us + 1;
            if (err1_al || err1_us) n_err1 <= n_err1 + 1;
        end else begin
            stall_r <= 1'b0;
        end
    end

    // Present the selected lanes and hold each until it is accepted
    task automatic send(input logic [63:0] d, input logic [3:0] lst,
                        input logic [31:0] dst, input logic [3:0] lanes);
        logic [3:0] pend;
        int g;
        pend = lanes;
        g = 0;
        s_tdata  = d;
        s_tlast  = lst;
        s_tdest  = dst;
        s_tvalid = pend;
        while (pend != 4'd0 && g < 200) begin
            @(negedge clk);
            if (pend[0] & s_tready[0]) lane0_acc = cyc + 1;
            pend = pend & ~s_tready;
            @(posedge clk);
            #1;
            s_tvalid = pend;
            g++;
        end
        check_value("send_accept", {60'd0, pend}, 64'd0);
    endtask

    task automatic wait_beats(input int target, input string tag);
        int g;
        g = 0;
        do begin
            @(posedge clk);
            g++;
        end while (q_data.size() < target && g < 400);
        #1;
        check_value(tag, 64'(q_data.size()), 64'(target));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int base;
    int al0;
    int us0;
    int un0;
    int nl;
    logic [63:0] d;
    logic adv;

    initial begin
        rst = 1'b1;
        s_tdata = 64'd0; s_tvalid = 4'd0; s_tlast = 4'd0;
        s_tid = 32'd0; s_tdest = 32'd0; s_tuser = 32'd0;
        s1_tdata = 16'd0; s1_tvalid = 1'b0; s1_tlast = 1'b0; m1_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_value("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
        check_value("rst_tready", {60'd0, s_tready}, 64'hF);
        check_value("rst_tlast", {63'd0, m_tlast}, 64'd0);
        check_value("rst_errs", {62'd0, err_al, err_us}, 64'd0);
        check_value("rst_tid", {56'd0, m_tid}, 64'd0);
        @(posedge clk); #1;

        // All lanes at once: 10..13, one cycle apart
        base = q_data.size(); al0 = n_err_al; us0 = n_err_us;
        send(64'h000D_000C_000B_000A, 4'b0000, 32'd0, 4'hF);
        wait_beats(base + 4, "t1_beats");
        idle(3);
        for (int k = 0; k < 4; k++) begin
            check_value("t1_data", {48'd0, q_data[base+k]}, 64'(10 + k));
            check_value("t1_last", {63'd0, q_last[base+k]}, 64'd0);
            check_value("t1_stamp", 64'(q_stamp[base+k]), 64'(lane0_acc + k));
        end
        check_value("t1_errs", 64'((n_err_al - al0) + (n_err_us - us0)), 64'd0);

        // Reverse arrival: lane 3 first, lane 0 last
        base = q_data.size();
        d = 64'h0017_0016_0015_0014;
        send(d, 4'b0000, 32'd0, 4'b1000);
        send(d, 4'b0000, 32'd0, 4'b0100);
        send(d, 4'b0000, 32'd0, 4'b0010);
        send(d, 4'b0000, 32'd0, 4'b0001);
        wait_beats(base + 4, "t2_beats");
        idle(2);
        for (int k = 0; k < 4; k++) begin
            check_value("t2_data", {48'd0, q_data[base+k]}, 64'(20 + k));
            check_value("t2_stamp", 64'(q_stamp[base+k]), 64'(lane0_acc + k));
        end

        // 8 rows under random backpressure, tlast only on row 8
        base = q_data.size(); al0 = n_err_al; us0 = n_err_us; un0 = n_unstable;
        rand_mode = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) d[16*i +: 16] = 16'(100 + 4*r + i);
            send(d, (r == 7) ? 4'hF : 4'h0, 32'd0, 4'hF);
        end
        wait_beats(base + 32, "t3_beats");
        rand_mode = 1'b0;
        idle(3);
        nl = 0;
        for (int k = 0; k < 32; k++) begin
            check_value("t3_data", {48'd0, q_data[base+k]}, 64'(100 + k));
            if (q_last[base+k]) nl++;
        end
        check_value("t3_tlast_count", 64'(nl), 64'd1);
        check_value("t3_tlast_beat32", {63'd0, q_last[base+31]}, 64'd1);
        check_value("t3_stable", 64'(n_unstable - un0), 64'd0);
        check_value("t3_errs", 64'((n_err_al - al0) + (n_err_us - us0)), 64'd0);

        // Misaligned tlast row followed by an aligned row
        base = q_data.size(); al0 = n_err_al; us0 = n_err_us;
        send(64'h0021_0020_001F_001E, 4'b0111, 32'd0, 4'hF);
        wait_beats(base + 4, "t4_beats");
        idle(3);
        check_value("t4_last", {60'd0, q_last[base+3], q_last[base+2], q_last[base+1], q_last[base]}, 64'b1000);
        check_value("t4_err_al", 64'(n_err_al - al0), 64'd1);
        check_value("t4_err_us", 64'(n_err_us - us0), 64'd0);
        send(64'h0025_0024_0023_0022, 4'b0000, 32'd0, 4'hF);
        wait_beats(base + 8, "t4b_beats");
        idle(3);
        check_value("t4b_err_al", 64'(n_err_al - al0), 64'd1);

        // tdest mismatch on lane 2: 5, 5, 7, 5
        base = q_data.size(); al0 = n_err_al; us0 = n_err_us;
        send(64'h003F_003E_003D_003C, 4'b0000, 32'h0507_0505, 4'hF);
        wait_beats(base + 4, "t5_beats");
        idle(3);
        check_value("t5_err_us", 64'(n_err_us - us0), 64'd1);
        check_value("t5_err_al", 64'(n_err_al - al0), 64'd0);
        check_value("t5_data2", {48'd0, q_data[base+2]}, 64'd62);
        check_value("t5_dest2", {56'd0, q_dest[base+2]}, 64'd7);

        // Reset mid-row with lane 2 held
        base = q_data.size(); al0 = n_err_al; us0 = n_err_us;
        send(64'h0000_0000_0029_0028, 4'b0000, 32'd0, 4'b0011);
        wait_beats(base + 2, "t6_pre_beats");
        hold_rdy = 1'b1;
        idle(1);
        send(64'h0000_002A_0000_0000, 4'b0000, 32'd0, 4'b0100);
        @(negedge clk);
        check_value("t6_held_valid", {63'd0, m_tvalid}, 64'd1);
        check_value("t6_held_data", {48'd0, m_tdata}, 64'd42);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_value("t6_rst_tvalid", {63'd0, m_tvalid}, 64'd0);
        check_value("t6_rst_tready", {60'd0, s_tready}, 64'hF);
        hold_rdy = 1'b0;
        @(posedge clk); #1;
        base = q_data.size();
        send(64'h0035_0034_0033_0032, 4'b0000, 32'd0, 4'hF);
        wait_beats(base + 4, "t6_beats");
        idle(4);
        check_value("t6_count", 64'(q_data.size()), 64'(base + 4));
        for (int k = 0; k < 4; k++)
            check_value("t6_data", {48'd0, q_data[base+k]}, 64'(50 + k));
        check_value("t6_errs", 64'((n_err_al - al0) + (n_err_us - us0)), 64'd0);

        // Single-lane instance: one beat per cycle, tlast passes through
        base = q1_data.size();
        s1_tvalid = 1'b1; s1_tdata = 16'd200; s1_tlast = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            adv = s1_tvalid & s1_tready;
            @(posedge clk); #1;
            if (adv) begin
                s1_tdata = s1_tdata + 16'd1;
                s1_tlast = ~s1_tlast;
            end
        end
        s1_tvalid = 1'b0;
        idle(4);
        check_value("p1_count", 64'(q1_data.size() - base), 64'd10);
        for (int k = 0; k < 10; k++) begin
            if (base + k < q1_data.size()) begin
                check_value("p1_data", {48'd0, q1_data[base+k]}, 64'(200 + k));
                check_value("p1_last", {63'd0, q1_last[base+k]}, 64'(k % 2));
                check_value("p1_rate", 64'(q1_stamp[base+k] - q1_stamp[base]), 64'(k));
            end
        end
        check_value("p1_errs", 64'(n_err1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
